alu_rr_arbiter: RTL

- Shares one ALU_32_Bit_WithFlags instance among NUM_REQ requesters using round-robin arbitration.
- Each requester offers an operation (A, B, F) with a valid/ready handshake.
- The block registers the winning operands onto the ALU inputs, samples Y/OVERFLOW/ZERO, and returns the result to the issuing requester two cycles after acceptance.
- Sits between requesting sequencers (e.g. a test-vector player or microcoded controller) and the ALU datapath. The ALU is instantiated outside this block and connected via the alu_* ports.

---
 rtl/alu_rr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one external ALU.
// Accepts one operation per cycle; the result returns to its owner two cycles after acceptance.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_A,
    input  logic [NUM_REQ*32-1:0] req_B,
    input  logic [NUM_REQ*3-1:0]  req_F,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           alu_A,
    output logic [31:0]           alu_B,
    output logic [2:0]            alu_F,
    input  logic [31:0]           alu_Y,
    input  logic                  alu_OVERFLOW,
    input  logic                  alu_ZERO,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_Y,
    output logic                  resp_OVERFLOW,
    output logic                  resp_ZERO,
    output logic                  busy
);

    localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic [2:0]         alu_f_q, alu_f_d;
    logic               s1_valid_q, s1_valid_d;
    logic [IDW-1:0]     s1_id_q, s1_id_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]        resp_y_q, resp_y_d;
    logic               resp_ovf_q, resp_ovf_d;
    logic               resp_zero_q, resp_zero_d;

    logic [NUM_REQ-1:0] rot_valid;
    logic [IDW-1:0]     grant_off;
    logic [IDW-1:0]     grant_idx;
    logic               grant_found;
    logic               accept;
    logic [IDW:0]       grant_sum;
    logic [IDW:0]       ptr_sum;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [2:0]         sel_f;

    // Rotate the requests so the pointer position lands at bit 0, then pick the lowest set bit.
    always_comb begin
        rot_valid   = NUM_REQ'({req_valid, req_valid} >> ptr_q);
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && rot_valid[k]) begin
                grant_found = 1'b1;
                grant_off   = k[IDW-1:0];
            end
        end
        grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
        if (grant_sum >= NREQ) begin
            grant_sum = grant_sum - NREQ;
        end
        grant_idx = grant_sum[IDW-1:0];
        accept    = grant_found && !RESET;
        req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_f = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == i[IDW-1:0]) begin
                sel_a = req_A[i*32 +: 32];
                sel_b = req_B[i*32 +: 32];
                sel_f = req_F[i*3 +: 3];
            end
        end
    end

    // Registers hold their last value when idle so the ALU inputs and the result stay quiet.
    always_comb begin
        ptr_sum = {1'b0, grant_idx} + (IDW+1)'(1);
        if (ptr_sum >= NREQ) begin
            ptr_sum = '0;
        end
        ptr_d        = accept ? ptr_sum[IDW-1:0] : ptr_q;
        alu_a_d      = accept ? sel_a : alu_a_q;
        alu_b_d      = accept ? sel_b : alu_b_q;
        alu_f_d      = accept ? sel_f : alu_f_q;
        s1_valid_d   = accept;
        s1_id_d      = accept ? grant_idx : s1_id_q;
        resp_valid_d = s1_valid_q ? (NUM_REQ'(1) << s1_id_q) : '0;
        resp_y_d     = s1_valid_q ? alu_Y : resp_y_q;
        resp_ovf_d   = s1_valid_q ? alu_OVERFLOW : resp_ovf_q;
        resp_zero_d  = s1_valid_q ? alu_ZERO : resp_zero_q;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            ptr_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_f_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            resp_valid_q <= '0;
            resp_y_q     <= '0;
            resp_ovf_q   <= 1'b0;
            resp_zero_q  <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_f_q      <= alu_f_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            resp_valid_q <= resp_valid_d;
            resp_y_q     <= resp_y_d;
            resp_ovf_q   <= resp_ovf_d;
            resp_zero_q  <= resp_zero_d;
        end
    end

    assign alu_A         = alu_a_q;
    assign alu_B         = alu_b_q;
    assign alu_F         = alu_f_q;
    assign resp_valid    = resp_valid_q;
    assign resp_Y        = resp_y_q;
    assign resp_OVERFLOW = resp_ovf_q;
    assign resp_ZERO     = resp_zero_q;
    assign busy          = s1_valid_q | (|resp_valid_q);

endmodule
